// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - MSB-first parallel-to-serial word converter with detector clear pulse
//
// Purpose: accepts a WIDTH-bit word on a valid/ready handshake and shifts it out
// MSB first, one bit per clock. An optional one-cycle det_clear pulse precedes
// each word so a downstream serial pattern detector can be reset between words.
//
// Optional feature macro: WORD_SERIALIZER_CLEAR_EN
//   defined   : IDLE -> CLEAR -> SHIFT, det_clear pulses in the CLEAR cycle
//   undefined : IDLE -> SHIFT, det_clear tied low, one cycle less latency
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   asynchronous active-low reset
//   load_valid  in   load_data holds a valid word
//   load_data   in   WIDTH-bit word to serialize
//   load_ready  out  block accepts a word this cycle
//   ser_bit     out  serial data, MSB first, 0 when ser_valid is low
//   ser_valid   out  ser_bit is meaningful
//   ser_last    out  ser_bit is the LSB of the word
//   det_clear   out  one-cycle clear pulse for the downstream detector
//   word_count  out  completed words, modulo 256

module word_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             det_clear,
  output logic [7:0]       word_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_word_count;
  logic             r_load_ready;
  logic             r_ser_bit;
  logic             r_ser_valid;
  logic             r_ser_last;

`ifdef WORD_SERIALIZER_CLEAR_EN
  logic             r_det_clear;
  assign det_clear = r_det_clear;
`else
  assign det_clear = 1'b0;
`endif

  assign load_ready = r_load_ready;
  assign ser_bit    = r_ser_bit;
  assign ser_valid  = r_ser_valid;
  assign ser_last   = r_ser_last;
  assign word_count = r_word_count;

  // Outputs are registered: each transition loads the values that belong to
  // the state being entered, so ser_bit always mirrors the MSB of r_shift
  // while in SHIFT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_word_count <= '0;
      r_load_ready <= 1'b0;
      r_ser_bit    <= 1'b0;
      r_ser_valid  <= 1'b0;
      r_ser_last   <= 1'b0;
`ifdef WORD_SERIALIZER_CLEAR_EN
      r_det_clear  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Ready rises on the first edge after reset release.
          r_load_ready <= 1'b1;
          if (load_valid && r_load_ready) begin
            r_shift      <= load_data;
            r_cnt        <= '0;
            r_load_ready <= 1'b0;
`ifdef WORD_SERIALIZER_CLEAR_EN
            r_det_clear  <= 1'b1;
            r_state      <= ST_CLEAR;
`else
            r_ser_valid  <= 1'b1;
            r_ser_bit    <= load_data[WIDTH-1];
            r_state      <= ST_SHIFT;
`endif
          end
        end
`ifdef WORD_SERIALIZER_CLEAR_EN
        ST_CLEAR: begin
          r_det_clear <= 1'b0;
          r_ser_valid <= 1'b1;
          r_ser_bit   <= r_shift[WIDTH-1];
          r_state     <= ST_SHIFT;
        end
`endif
        ST_SHIFT: begin
          if (r_cnt == LP_CNT_LAST) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_ser_valid  <= 1'b0;
            r_ser_bit    <= 1'b0;
            r_ser_last   <= 1'b0;
            r_load_ready <= 1'b1;
            r_word_count <= r_word_count + 8'd1;
          end else begin
            r_shift    <= r_shift << 1;
            r_ser_bit  <= r_shift[WIDTH-2];
            r_cnt      <= r_cnt + LP_CNT_ONE;
            r_ser_last <= ((r_cnt + LP_CNT_ONE) == LP_CNT_LAST);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - randomized schedule-model bench for word_serializer

module tb_word_serializer;

  localparam int W = 8;
`ifdef WORD_SERIALIZER_CLEAR_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif
  localparam int MAXC  = 8192;
  localparam int NEVER = 1 << 30;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         ser_bit;
  logic         ser_valid;
  logic         ser_last;
  logic         det_clear;
  logic [7:0]   word_count;

  word_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .det_clear  (det_clear),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ready_cycle = NEVER;
  int   hs_count = 0;
  logic [7:0] model_wc;

  // Expected output timeline, indexed by cycle number.
  logic exp_valid [MAXC];
  logic exp_bit   [MAXC];
  logic exp_last  [MAXC];
  logic exp_clr   [MAXC];
  logic exp_inc   [MAXC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_valid[i] = 1'b0;
      exp_bit[i]   = 1'b0;
      exp_last[i]  = 1'b0;
      exp_clr[i]   = 1'b0;
      exp_inc[i]   = 1'b0;
    end
  endtask

  // A word accepted at the end of cycle cyc fills the timeline directly.
  task automatic schedule(input logic [W-1:0] d);
    if (cyc + D + W + 1 >= MAXC) begin
      $display("FAIL cycle_budget at cycle %0d", cyc);
      $fatal(1, "timeline exhausted");
    end
    if (D == 1) exp_clr[cyc + 1] = 1'b1;
    for (int i = 0; i < W; i++) begin
      exp_valid[cyc + 1 + D + i] = 1'b1;
      exp_bit[cyc + 1 + D + i]   = d[W-1-i];
      exp_last[cyc + 1 + D + i]  = (i == W - 1);
    end
    ready_cycle = cyc + D + W + 1;
    exp_inc[ready_cycle] = 1'b1;
    hs_count++;
  endtask

  task automatic check_outputs();
    if (exp_inc[cyc]) model_wc = model_wc + 8'd1;
    check_eq("load_ready", 32'(load_ready), 32'(cyc >= ready_cycle));
    check_eq("ser_valid",  32'(ser_valid),  32'(exp_valid[cyc]));
    check_eq("ser_bit",    32'(ser_bit),    32'(exp_bit[cyc]));
    check_eq("ser_last",   32'(ser_last),   32'(exp_last[cyc]));
    check_eq("det_clear",  32'(det_clear),  32'(exp_clr[cyc]));
    check_eq("word_count", 32'(word_count), 32'(model_wc));
  endtask

  task automatic run_cycle(input logic lv, input logic [W-1:0] d);
    @(negedge clk);
    check_outputs();
    load_valid = lv;
    load_data  = d;
    if (lv && cyc >= ready_cycle) schedule(d);
    @(posedge clk);
    cyc++;
  endtask

  // Called just after an active edge: reset falls between edges.
  task automatic drop_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_load_ready", 32'(load_ready), 32'd0);
    check_eq("rst_ser_valid",  32'(ser_valid),  32'd0);
    check_eq("rst_ser_bit",    32'(ser_bit),    32'd0);
    check_eq("rst_ser_last",   32'(ser_last),   32'd0);
    check_eq("rst_det_clear",  32'(det_clear),  32'd0);
    check_eq("rst_word_count", 32'(word_count), 32'd0);
    clear_from(cyc);
    model_wc    = 8'd0;
    ready_cycle = NEVER;
  endtask

  task automatic release_reset();
    #2 reset = 1'b1;
    ready_cycle = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0);
  endtask

  initial begin
    int target;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    model_wc   = 8'd0;
    clear_from(0);
    #1 reset = 1'b0;

    idle(3);
    release_reset();
    idle(2);

    // 0x06: bits 0000_0110
    run_cycle(1'b1, 8'h06);
    idle(W + 4);

    // 0xFF with a 0x12 offered while busy
    run_cycle(1'b1, 8'hFF);
    idle(2);
    run_cycle(1'b1, 8'h12);
    run_cycle(1'b1, 8'h12);
    idle(W + 4);

    // valid held high: 0x03 then 0x09 back to back
    target = hs_count + 1;
    for (int t = 0; t < 20 && hs_count < target; t++) run_cycle(1'b1, 8'h03);
    target = hs_count + 1;
    for (int t = 0; t < 20 && hs_count < target; t++) run_cycle(1'b1, 8'h09);
    idle(W + 4);

    // reset while bit 3 of 0xA5 is on the line, then 0x01
    run_cycle(1'b1, 8'hA5);
    idle(D + 3);
    drop_reset();
    idle(2);
    release_reset();
    idle(1);
    run_cycle(1'b1, 8'h01);
    idle(W + 4);

    // 257 words from a fresh count to cover the wrap
    drop_reset();
    idle(1);
    release_reset();
    idle(1);
    target = hs_count + 257;
    for (int t = 0; t < 257 * (W + 4) && hs_count < target; t++) run_cycle(1'b1, W'($urandom));
    idle(W + 4);

    // random traffic with occasional resets
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 149) == 0) begin
        drop_reset();
        idle(1);
        release_reset();
        idle(1);
      end else begin
        run_cycle($urandom_range(0, 2) != 0, W'($urandom));
      end
    end
    idle(W + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the word length in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port load_valid, input, 1 bit: the upstream word on load_data is valid.
REQ-005 SHALL have port load_data, input, WIDTH bits: the parallel word to serialize.
REQ-006 SHALL have port load_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 SHALL have port ser_bit, output, 1 bit: the serial bit for the downstream FSM detector, MSB first.
REQ-008 SHALL have port ser_valid, output, 1 bit: ser_bit is meaningful this cycle.
REQ-009 SHALL have port ser_last, output, 1 bit: ser_bit is the LSB of the current word.
REQ-010 SHALL have port det_clear, output, 1 bit: a one-cycle active-high clear pulse for the downstream detector.
REQ-011 SHALL have port word_count, output, 8 bits: the number of fully serialized words, modulo 256.

Function
REQ-012 SHALL implement states IDLE, CLEAR and SHIFT; every output SHALL be registered.
REQ-013 IDLE: load_ready=1 and ser_valid=0; a handshake (load_valid & load_ready at an edge) SHALL capture load_data into the shift register and go to CLEAR.
REQ-014 CLEAR: det_clear=1 for exactly one cycle, load_ready=0 and ser_valid=0; the next state SHALL be SHIFT.
REQ-015 SHIFT: ser_valid=1 and ser_bit=shift_reg[WIDTH-1]; the register SHALL shift left by one each cycle and a bit counter SHALL count 0..WIDTH-1.
REQ-016 ser_last SHALL be 1 only when the counter equals WIDTH-1; on that cycle's closing edge the block SHALL go to IDLE and increment word_count.
REQ-017 Latency: for a handshake at edge k, det_clear SHALL be high in cycle k+1, bits SHALL appear in cycles k+2..k+1+WIDTH, and load_ready SHALL be 1 again in cycle k+2+WIDTH.
REQ-018 load_valid while load_ready=0 SHALL be ignored and load_data SHALL not be sampled.
REQ-019 word_count SHALL wrap from 255 to 0 with no flag.
REQ-020 load_valid held continuously SHALL give back-to-back words separated only by one IDLE cycle plus the CLEAR cycle.
REQ-021 ser_bit SHALL be 0 whenever ser_valid=0.

Reset
REQ-022 Asserting reset (low) SHALL immediately force IDLE, shift register=0, counter=0, word_count=0, ser_bit=0, ser_valid=0, ser_last=0, det_clear=0 and load_ready=0, with no dependency on clk.
REQ-023 load_ready SHALL go to 1 at the first clk edge after reset is released.
REQ-024 A reset during CLEAR or SHIFT SHALL abandon the word in progress and SHALL NOT count it in word_count.

Configuration
REQ-025 With macro WORD_SERIALIZER_CLEAR_EN defined, the CLEAR state and the det_clear pulse SHALL be present as specified above.
REQ-026 Without WORD_SERIALIZER_CLEAR_EN, the CLEAR state SHALL be omitted, IDLE SHALL go directly to SHIFT, det_clear SHALL be tied to 0, and every latency in REQ-017 SHALL shrink by one cycle.

Verification
REQ-027 WIDTH=8 with CLEAR_EN, load 0x06 -> det_clear in cycle k+1; ser_bit 0,0,0,0,0,1,1,0 in cycles k+2..k+9; ser_last only in cycle k+9; word_count=1.
REQ-028 Load 0xFF, then pulse load_valid with 0x12 during SHIFT -> serialized bits are all 1; 0x12 is never captured; word_count=1.
REQ-029 load_valid held high with 0x03, then 0x09 -> second det_clear exactly 2 cycles after the first ser_last; both words are emitted intact.
REQ-030 Drive reset low mid-way between clk edges during bit 3 of 0xA5 -> all outputs go to 0 at once; after release, load 0x01 gives bits 0000_0001 and word_count=1.
REQ-031 Serialize 257 words -> word_count reads 255 after word 255, 0 after word 256, and 1 after word 257.
REQ-032 Without CLEAR_EN, load 0x80 -> det_clear never asserts; ser_bit=1 in cycle k+1, then 0 for 7 cycles; load_ready is 1 in cycle k+1+WIDTH.
